// File: rtl/radix2_divider_if.sv
// Operand/result handshake bundle for radix2_divider.
// The master drives a request; the slave returns registered results and status.
interface radix2_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] den;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, num, den,
    input  quot, rem, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, num, den,
    output quot, rem, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/radix2_divider.sv
// Multi-cycle restoring divider: one shift-subtract per clock, fixed latency,
// optional two's-complement mode with divide-by-zero and MIN/-1 overflow flags.
module radix2_divider #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  radix2_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] r_den;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_sn;
  logic             r_sd;
  logic             r_dbz;
  logic             r_ovf;

  logic             w_idle_like;
  logic             w_accept;
  logic             w_dbz;
  logic             w_ovf;
  logic             w_num_neg;
  logic             w_den_neg;
  logic [WIDTH:0]   w_r_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept    = bus.start && w_idle_like;
  assign w_dbz       = (r_den == '0);
  assign w_ovf       = SIGNED && (r_num == {1'b1, {(WIDTH-1){1'b0}}}) && (r_den == '1);
  assign w_num_neg   = SIGNED && r_num[WIDTH-1];
  assign w_den_neg   = SIGNED && r_den[WIDTH-1];

  // Partial remainder is always < divisor, so the (WIDTH+1)-bit difference never
  // wraps and its top bit alone tells whether the subtraction fits.
  assign w_r_shift = {r_r, r_q[WIDTH-1]};
  assign w_diff    = w_r_shift - {1'b0, r_d};
  assign w_ge      = ~w_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = (w_dbz || w_ovf) ? S_FIX : S_CALC;
      S_CALC:  if (r_cnt == '0) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  if (bus.start) w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == S_LOAD) || (r_state == S_CALC) || (r_state == S_FIX);
    bus.done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num  <= '0;
      r_den  <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_r    <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_sn   <= 1'b0;
      r_sd   <= 1'b0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_num <= bus.num;
            r_den <= bus.den;
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
          end
        end
        S_LOAD: begin
          r_sn  <= w_num_neg;
          r_sd  <= w_den_neg;
          r_q   <= w_num_neg ? -r_num : r_num;
          r_d   <= w_den_neg ? -r_den : r_den;
          r_r   <= '0;
          r_cnt <= CW'(WIDTH - 1);
        end
        S_CALC: begin
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_r   <= w_ge ? w_diff[WIDTH-1:0] : w_r_shift[WIDTH-1:0];
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          // Exceptional operands bypassed CALC; their results come straight from the latched inputs.
          if (w_dbz) begin
            r_quot <= '1;
            r_rem  <= r_num;
            r_dbz  <= 1'b1;
          end else if (w_ovf) begin
            r_quot <= r_num;
            r_rem  <= '0;
            r_ovf  <= 1'b1;
          end else begin
            r_quot <= (r_sn ^ r_sd) ? -r_q : r_q;
            r_rem  <= r_sn ? -r_r : r_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quot        = r_quot;
  assign bus.rem         = r_rem;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_radix2_divider.sv
// Self-checking bench for radix2_divider: four instances (8u, 8s, 16s, 32u),
// scoreboard of model results, latency/busy checks, abort and back-to-back cases.
module tb_radix2_divider;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  radix2_divider_if #(.WIDTH(8))  u8_if  ();
  radix2_divider_if #(.WIDTH(8))  s8_if  ();
  radix2_divider_if #(.WIDTH(16)) s16_if ();
  radix2_divider_if #(.WIDTH(32)) u32_if ();

  radix2_divider #(.WIDTH(8),  .SIGNED(1'b0)) u_u8  (.clk(clk), .rst(rst), .bus(u8_if));
  radix2_divider #(.WIDTH(8),  .SIGNED(1'b1)) u_s8  (.clk(clk), .rst(rst), .bus(s8_if));
  radix2_divider #(.WIDTH(16), .SIGNED(1'b1)) u_s16 (.clk(clk), .rst(rst), .bus(s16_if));
  radix2_divider #(.WIDTH(32), .SIGNED(1'b0)) u_u32 (.clk(clk), .rst(rst), .bus(u32_if));

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  function automatic int width_of(input int sel);
    case (sel)
      0, 1:    return 8;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic bit signed_of(input int sel);
    return (sel == 1) || (sel == 2);
  endfunction

  // Reference: native 64-bit division; signed / and % truncate toward zero.
  function automatic exp_t model(input int sel, input logic [63:0] num_in, input logic [63:0] den_in);
    exp_t        e;
    int          w;
    logic [63:0] mask;
    logic [63:0] n;
    logic [63:0] d;
    longint      sn;
    longint      sd;
    w     = width_of(sel);
    mask  = (64'd1 << w) - 64'd1;
    n     = num_in & mask;
    d     = den_in & mask;
    sn    = $signed(n << (64 - w)) >>> (64 - w);
    sd    = $signed(d << (64 - w)) >>> (64 - w);
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = w + 2;
    if (d == 64'd0) begin
      e.q = mask; e.r = n; e.dbz = 1'b1; e.lat = 2;
    end else if (signed_of(sel) && n == (64'd1 << (w - 1)) && d == mask) begin
      e.q = n; e.r = 64'd0; e.ovf = 1'b1; e.lat = 2;
    end else if (signed_of(sel)) begin
      e.q = 64'(sn / sd) & mask;
      e.r = 64'(sn % sd) & mask;
    end else begin
      e.q = n / d;
      e.r = n % d;
    end
    return e;
  endfunction

  task automatic set_in(input int sel, input logic st, input logic [63:0] n, input logic [63:0] d);
    case (sel)
      0: begin u8_if.start = st;  u8_if.num = n[7:0];   u8_if.den = d[7:0];   end
      1: begin s8_if.start = st;  s8_if.num = n[7:0];   s8_if.den = d[7:0];   end
      2: begin s16_if.start = st; s16_if.num = n[15:0]; s16_if.den = d[15:0]; end
      default: begin u32_if.start = st; u32_if.num = n[31:0]; u32_if.den = d[31:0]; end
    endcase
  endtask

  task automatic read_out(input int sel, output logic [63:0] q, output logic [63:0] r,
                          output logic busy, output logic done, output logic dbz, output logic ovf);
    case (sel)
      0: begin q = 64'(u8_if.quot); r = 64'(u8_if.rem); busy = u8_if.busy; done = u8_if.done;
               dbz = u8_if.div_by_zero; ovf = u8_if.overflow; end
      1: begin q = 64'(s8_if.quot); r = 64'(s8_if.rem); busy = s8_if.busy; done = s8_if.done;
               dbz = s8_if.div_by_zero; ovf = s8_if.overflow; end
      2: begin q = 64'(s16_if.quot); r = 64'(s16_if.rem); busy = s16_if.busy; done = s16_if.done;
               dbz = s16_if.div_by_zero; ovf = s16_if.overflow; end
      default: begin q = 64'(u32_if.quot); r = 64'(u32_if.rem); busy = u32_if.busy; done = u32_if.done;
               dbz = u32_if.div_by_zero; ovf = u32_if.overflow; end
    endcase
  endtask

  // Issue one request and wait (bounded) for done; lat = edges after the accept edge.
  task automatic do_op(input int sel, input logic [63:0] n, input logic [63:0] d,
                       output int lat, output int busy_cyc, output logic done0, output logic [63:0] q_prev,
                       output logic [63:0] q, output logic [63:0] r, output logic dbz, output logic ovf);
    logic bz;
    logic dn;
    @(negedge clk); set_in(sel, 1'b1, n, d);
    @(posedge clk); #1; set_in(sel, 1'b0, n, d);
    lat = -1; busy_cyc = 0; done0 = 1'b0; q_prev = '0;
    for (int i = 0; i <= 80; i++) begin
      read_out(sel, q, r, bz, dn, dbz, ovf);
      if (i == 0) begin done0 = dn; q_prev = q; end
      if (dn) begin lat = i; break; end
      if (bz) busy_cyc++;
      @(posedge clk); #1;
    end
    $display("[TB] op sel=%0d num=%0h den=%0h -> quot=%0h rem=%0h dbz=%0b ovf=%0b lat=%0d",
             sel, n, d, q, r, dbz, ovf, lat);
  endtask

  task automatic test_reset();
    logic [63:0] q, r;
    logic bz, dn, z, o;
    rst = 1'b1;
    for (int s = 0; s < 4; s++) set_in(s, 1'b0, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      read_out(s, q, r, bz, dn, z, o);
      tests++;
      if ({q, r, bz, dn, z, o} !== '0) begin
        fails++;
        $display("FAIL reset_state sel=%0d got quot=%0h rem=%0h busy=%0b done=%0b dbz=%0b ovf=%0b want all 0",
                 s, q, r, bz, dn, z, o);
      end
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    read_out(0, q, r, bz, dn, z, o);
    tests++;
    if ({bz, dn} !== 2'b00) begin
      fails++;
      $display("FAIL idle_after_reset got busy=%0b done=%0b want 0 0", bz, dn);
    end
  endtask

  task automatic test_table(input int sel, input string name,
                            input logic [63:0] nums[4], input logic [63:0] dens[4]);
    exp_t e;
    int lat, bc;
    logic d0, z, o;
    logic [63:0] qp, q, r;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model(sel, nums[i], dens[i]));
      do_op(sel, nums[i], dens[i], lat, bc, d0, qp, q, r, z, o);
      e = sb.pop_front();
      tests++;
      if (q !== e.q || r !== e.r || z !== e.dbz || o !== e.ovf) begin
        fails++;
        $display("FAIL %s_result[%0d] got q=%0h r=%0h dbz=%0b ovf=%0b want q=%0h r=%0h dbz=%0b ovf=%0b",
                 name, i, q, r, z, o, e.q, e.r, e.dbz, e.ovf);
      end
      tests++;
      if (lat !== e.lat || bc !== e.lat) begin
        fails++;
        $display("FAIL %s_timing[%0d] got lat=%0d busy=%0d want %0d", name, i, lat, bc, e.lat);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [63:0] nums[4] = '{64'd200, 64'd5, 64'd0, 64'd77};
    logic [63:0] dens[4] = '{64'd7, 64'd9, 64'd3, 64'd0};
    test_table(0, "unsigned8", nums, dens);
  endtask

  task automatic test_signed();
    logic [63:0] nums[4] = '{64'hF9, 64'h07, 64'h80, 64'h80};
    logic [63:0] dens[4] = '{64'h02, 64'hFE, 64'hFF, 64'h00};
    test_table(1, "signed8", nums, dens);
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int n;
    logic [63:0] q, r;
    logic bz, dn, z, o;
    sb.push_back(model(0, 64'd200, 64'd7));
    @(negedge clk); set_in(0, 1'b1, 64'd200, 64'd7);
    @(posedge clk); #1; set_in(0, 1'b0, 64'd200, 64'd7);
    repeat (4) @(posedge clk);
    @(negedge clk); set_in(0, 1'b1, 64'd100, 64'd3);
    @(posedge clk); #1; set_in(0, 1'b0, 64'd100, 64'd3);
    n = 5;
    dn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      read_out(0, q, r, bz, dn, z, o);
      if (dn) break;
      @(posedge clk); #1; n++;
    end
    e = sb.pop_front();
    tests++;
    if (!dn || n !== e.lat || q !== e.q || r !== e.r) begin
      fails++;
      $display("FAIL ignore_start got done=%0b lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
               dn, n, q, r, e.lat, e.q, e.r);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2;
    int lat, bc;
    logic d0, z, o;
    logic [63:0] qp, q, r;
    sb.push_back(model(0, 64'd100, 64'd9));
    sb.push_back(model(0, 64'd50, 64'd6));
    do_op(0, 64'd100, 64'd9, lat, bc, d0, qp, q, r, z, o);
    e1 = sb.pop_front();
    tests++;
    if (q !== e1.q || r !== e1.r || lat !== e1.lat) begin
      fails++;
      $display("FAIL b2b_first got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=%0d", q, r, lat, e1.q, e1.r, e1.lat);
    end
    do_op(0, 64'd50, 64'd6, lat, bc, d0, qp, q, r, z, o);
    e2 = sb.pop_front();
    tests++;
    if (d0 !== 1'b0 || qp !== e1.q) begin
      fails++;
      $display("FAIL b2b_accept got done=%0b held_quot=%0d want done=0 held_quot=%0d", d0, qp, e1.q);
    end
    tests++;
    if (q !== e2.q || r !== e2.r || lat !== e2.lat) begin
      fails++;
      $display("FAIL b2b_second got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=%0d", q, r, lat, e2.q, e2.r, e2.lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] q, r;
    logic bz, dn, z, o;
    int done_seen;
    int busy_seen;
    @(negedge clk); set_in(0, 1'b1, 64'd200, 64'd7);
    @(posedge clk); #1; set_in(0, 1'b0, 64'd200, 64'd7);
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    read_out(0, q, r, bz, dn, z, o);
    tests++;
    if ({q, r, bz, dn, z, o} !== '0) begin
      fails++;
      $display("FAIL reset_mid got quot=%0h rem=%0h busy=%0b done=%0b want all 0", q, r, bz, dn);
    end
    @(negedge clk); rst = 1'b0;
    done_seen = 0;
    repeat (14) begin
      @(posedge clk); #1;
      read_out(0, q, r, bz, dn, z, o);
      if (dn || bz) done_seen++;
    end
    tests++;
    if (done_seen !== 0) begin
      fails++;
      $display("FAIL reset_abort got %0d active cycles want 0", done_seen);
    end
    @(negedge clk); rst = 1'b1; set_in(0, 1'b1, 64'd200, 64'd7);
    @(posedge clk); #1; rst = 1'b0; set_in(0, 1'b0, 64'd200, 64'd7);
    busy_seen = 0;
    repeat (4) begin
      read_out(0, q, r, bz, dn, z, o);
      if (bz || dn) busy_seen++;
      @(posedge clk); #1;
    end
    tests++;
    if (busy_seen !== 0) begin
      fails++;
      $display("FAIL reset_start_same_edge got %0d active cycles want 0", busy_seen);
    end
  endtask

  task automatic test_random(input int sel, input int count);
    exp_t e;
    int lat, bc, w;
    logic d0, z, o;
    logic [63:0] n, d, qp, q, r;
    w = width_of(sel);
    for (int i = 0; i < count; i++) begin
      n = {$urandom, $urandom};
      d = {$urandom, $urandom} >> (64 - w + $urandom_range(0, w - 1));
      if ($urandom_range(0, 7) == 0) d = 64'd0;
      if (signed_of(sel) && $urandom_range(0, 7) == 0) begin
        n = 64'd1 << (w - 1);
        d = '1;
      end
      sb.push_back(model(sel, n, d));
      do_op(sel, n, d, lat, bc, d0, qp, q, r, z, o);
      e = sb.pop_front();
      tests++;
      if (q !== e.q || r !== e.r || z !== e.dbz || o !== e.ovf || lat !== e.lat || bc !== e.lat) begin
        fails++;
        $display("FAIL random_w%0d[%0d] got q=%0h r=%0h dbz=%0b ovf=%0b lat=%0d want q=%0h r=%0h dbz=%0b ovf=%0b lat=%0d",
                 w, i, q, r, z, o, lat, e.q, e.r, e.dbz, e.ovf, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random(2, 30);
    test_random(3, 30);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
